// File: rtl/gb_io_pkg.sv
// Shared GB I/O definitions for the OAM DMA path.
//   ADDR_DMA     : DMA page register address after the MegaDuck swizzle.
//   OAM_LEN      : bytes per OAM DMA transfer.
//   ECHO_BASE/OFS: echo RAM window (E0xx..FFxx) and its offset down to WRAM.
//   dma_state_t  : OAM DMA engine states.
//   dma_src_page : maps a written page to the page actually read.
package gb_io_pkg;

  localparam logic [15:0] ADDR_DMA  = 16'hFF46;
  localparam int          OAM_LEN   = 160;
  localparam logic [7:0]  ECHO_BASE = 8'hE0;
  localparam logic [7:0]  ECHO_OFS  = 8'h20;

  typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_XFER} dma_state_t;

  // Echo RAM mirrors WRAM, so pages E0..FF fetch from C0..DF.
  function automatic logic [7:0] dma_src_page(input logic [7:0] page);
    return (page >= ECHO_BASE) ? page - ECHO_OFS : page;
  endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine, downstream of the MegaDuck address swizzle.
// A write to FF46 latches a page and, START_DELAY ce ticks later, copies
// LENGTH bytes from {srcpage,00} into OAM at one byte per M-cycle.
//   clk_sys, reset          : clock, synchronous active-high reset
//   ce                      : M-cycle enable; state only moves when ce=1
//   cpu_addr/wr/di, cpu_sel : CPU register write port, FF46 decode
//   cpu_do                  : last written page
//   dma_rd, dma_addr, dma_di: source read request/address, data next tick
//   oam_wr/addr/do          : OAM write port, oam_wr one clk_sys wide
//   dma_active              : CPU bus blocked, OAM owned by DMA
// LENGTH must be in 1..255 (idx is 8 bits).
module oam_dma_ctrl
  import gb_io_pkg::*;
#(
  parameter int LENGTH      = OAM_LEN,
  parameter int START_DELAY = 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_di,
  output logic        cpu_sel,
  output logic [7:0]  cpu_do,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  input  logic [7:0]  dma_di,
  output logic        oam_wr,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_do,
  output logic        dma_active
);

  localparam logic [7:0] LEN8 = 8'(LENGTH);
  localparam logic [7:0] DLY0 = 8'(START_DELAY - 1);

  dma_state_t state, state_nxt;
  logic [7:0] page;      // last page written by the CPU
  logic [7:0] xpage;     // source page of the transfer currently running
  logic [7:0] idx, pend_idx, dly;
  logic       pend_valid;

  logic       trig, busy, entering;
  logic       wr_en, rd_en, rd_stop;
  logic [7:0] rd_idx, rd_page;

  assign cpu_sel    = (cpu_addr == ADDR_DMA);
  assign cpu_do     = page;
  assign dma_active = dma_rd | pend_valid;

  assign trig     = ce & cpu_wr & cpu_sel;
  assign busy     = dma_rd | pend_valid;
  assign entering = (state == DMA_START) && (dly == 8'd0);

  always_ff @(posedge clk_sys) begin
    if (reset) state <= DMA_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    rd_stop   = 1'b0;
    rd_idx    = idx;
    rd_page   = xpage;
    if (ce) begin
      // a byte read on the previous tick always lands, even across a restart
      wr_en = pend_valid;
      case (state)
        DMA_START: begin
          if (entering) begin
            // entry tick: old transfer is dropped, new one reads index 0
            rd_en     = 1'b1;
            rd_idx    = 8'd0;
            rd_page   = dma_src_page(page);
            state_nxt = DMA_XFER;
          end else if (busy) begin
            // previous transfer keeps running while the delay counts down
            if (idx < LEN8) rd_en   = 1'b1;
            else            rd_stop = 1'b1;
          end
        end
        DMA_XFER: begin
          if (idx < LEN8) rd_en = 1'b1;
          else begin
            rd_stop   = 1'b1;
            state_nxt = DMA_IDLE;
          end
        end
        default: ;
      endcase
      if (trig) state_nxt = DMA_START;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      page       <= 8'h00;
      xpage      <= 8'h00;
      dma_rd     <= 1'b0;
      dma_addr   <= 16'h0000;
      oam_wr     <= 1'b0;
      oam_addr   <= 8'h00;
      oam_do     <= 8'h00;
      idx        <= 8'h00;
      pend_idx   <= 8'h00;
      pend_valid <= 1'b0;
      dly        <= 8'h00;
    end else begin
      oam_wr <= 1'b0;
      if (ce) begin
        if (wr_en) begin
          oam_wr   <= 1'b1;
          oam_addr <= pend_idx;
          oam_do   <= dma_di;
        end
        if (rd_en) begin
          dma_rd     <= 1'b1;
          dma_addr   <= {rd_page, rd_idx};
          pend_idx   <= rd_idx;
          pend_valid <= 1'b1;
          idx        <= rd_idx + 8'd1;
        end else if (rd_stop) begin
          dma_rd     <= 1'b0;
          pend_valid <= 1'b0;
        end
        if (entering) xpage <= rd_page;
        if (trig) begin
          page <= cpu_di;
          dly  <= DLY0;
        end else if (state == DMA_START && dly != 8'd0) begin
          dly <= dly - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: expected OAM writes are queued when a
// transfer is triggered and popped by a monitor on every oam_wr.
module tb_oam_dma_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ce      = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_wr  = 1'b0;
  logic [7:0]  cpu_di  = 8'h00;
  logic        cpu_sel;
  logic [7:0]  cpu_do;
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic [7:0]  dma_di;
  logic        oam_wr;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_do;
  logic        dma_active;

  int total = 0;
  int bad   = 0;
  logic [15:0] sb[$];   // {oam_addr, oam_data}
  logic echo_mode = 1'b0;

  oam_dma_ctrl dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce),
    .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_di(cpu_di),
    .cpu_sel(cpu_sel), .cpu_do(cpu_do),
    .dma_rd(dma_rd), .dma_addr(dma_addr), .dma_di(dma_di),
    .oam_wr(oam_wr), .oam_addr(oam_addr), .oam_do(oam_do),
    .dma_active(dma_active)
  );

  always #5 clk_sys = ~clk_sys;

  // source memory: page C1 gives i^5A
  function automatic logic [7:0] src_data(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h9B;
  endfunction

  assign dma_di = src_data(dma_addr);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_xfer(input logic [7:0] sp, input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] ii;
      ii = 8'(i);
      sb.push_back({ii, src_data({sp, ii})});
    end
  endtask

  // the posedge between the two negedges is the trigger tick T0
  task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    cpu_addr = a; cpu_di = d; cpu_wr = 1'b1; ce = 1'b1;
    @(negedge clk_sys);
    cpu_wr = 1'b0; cpu_addr = 16'h0000;
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(posedge clk_sys);
      n++;
    end
    repeat (3) @(posedge clk_sys);
    #2;
    chk(tag, sb.size(), 0);
    chk({tag, "_idle"}, dma_active, 1'b0);
  endtask

  // monitor: every oam_wr must follow a ce tick and match the scoreboard
  always begin : mon
    logic        ce_s;
    logic [15:0] e;
    @(posedge clk_sys);
    ce_s = ce;
    #1;
    if (oam_wr) begin
      chk("wr_on_ce", ce_s, 1'b1);
      if (sb.size() == 0) chk("wr_extra", oam_wr, 1'b0);
      else begin
        e = sb.pop_front();
        chk("oam_addr", oam_addr, e[15:8]);
        chk("oam_data", oam_do, e[7:0]);
      end
    end
    if (echo_mode && dma_rd) chk("echo_page", dma_addr[15:8], 8'hC3);
  end

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    #1;
    chk("rst_act", dma_active, 1'b0);
    chk("rst_rd", dma_rd, 1'b0);
    chk("rst_wr", oam_wr, 1'b0);
    chk("rst_cpu_do", cpu_do, 8'h00);
    chk("rst_addr", dma_addr, 16'h0000);

    // register decode
    begin
      logic [15:0] al [4];
      logic        sl [4];
      al = '{16'hFF45, 16'hFF46, 16'hFF47, 16'hFF1A};
      sl = '{1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
        @(negedge clk_sys);
        cpu_addr = al[i];
        #1;
        chk("cpu_sel", cpu_sel, sl[i]);
      end
    end

    // basic copy with cycle-exact timing
    push_xfer(8'hC1, 160);
    reg_write(16'hFF46, 8'hC1);
    for (int k = 1; k <= 162; k++) begin
      @(posedge clk_sys);
      #2;
      if (k == 1) begin
        chk("t1_rd", dma_rd, 1'b1);
        chk("t1_addr", dma_addr, 16'hC100);
        chk("t1_act", dma_active, 1'b1);
        chk("t1_nowr", oam_wr, 1'b0);
      end
      if (k == 2) begin
        chk("t2_wr", oam_wr, 1'b1);
        chk("t2_addr", oam_addr, 8'd0);
      end
      if (k == 160) chk("t160_act", dma_active, 1'b1);
      if (k == 161) begin
        chk("t161_wr", oam_wr, 1'b1);
        chk("t161_addr", oam_addr, 8'd159);
        chk("t161_act", dma_active, 1'b0);
      end
      if (k == 162) chk("t162_wr", oam_wr, 1'b0);
    end
    chk("cpu_do_c1", cpu_do, 8'hC1);
    drain("basic", 300);

    // echo mapping: E3 reads from C3
    echo_mode = 1'b1;
    push_xfer(8'hC3, 160);
    reg_write(16'hFF46, 8'hE3);
    drain("echo", 400);
    echo_mode = 1'b0;
    chk("cpu_do_e3", cpu_do, 8'hE3);

    // restart at idx=50: old bytes 0..49 land, then a full D0 copy
    push_xfer(8'hC1, 50);
    push_xfer(8'hD0, 160);
    reg_write(16'hFF46, 8'hC1);
    for (int k = 1; k <= 49; k++) begin
      @(posedge clk_sys);
      #2;
      chk("rs_old_act", dma_active, 1'b1);
    end
    reg_write(16'hFF46, 8'hD0);
    for (int k = 1; k <= 161; k++) begin
      @(posedge clk_sys);
      #2;
      if (k <= 160) chk("rs_act", dma_active, 1'b1);
      else          chk("rs_end", dma_active, 1'b0);
      if (k == 1) chk("rs_addr", dma_addr, 16'hD000);
    end
    drain("restart", 300);

    // ce 1-in-4 during a transfer
    push_xfer(8'h80, 160);
    reg_write(16'hFF46, 8'h80);
    for (int n = 0; n < 1200 && sb.size() != 0; n++) begin
      @(negedge clk_sys);
      ce = (n % 4 == 0);
    end
    @(negedge clk_sys);
    ce = 1'b1;
    drain("ce_gate", 100);

    // reset mid-transfer
    push_xfer(8'hC1, 160);
    reg_write(16'hFF46, 8'hC1);
    repeat (80) @(posedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b1;
    sb.delete();
    @(posedge clk_sys);
    #2;
    chk("mid_rst_act", dma_active, 1'b0);
    chk("mid_rst_wr", oam_wr, 1'b0);
    chk("mid_rst_cpu_do", cpu_do, 8'h00);
    chk("mid_rst_rd", dma_rd, 1'b0);
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (10) @(posedge clk_sys);
    #2;
    chk("post_rst_idle", dma_active, 1'b0);
    push_xfer(8'hC2, 160);
    reg_write(16'hFF46, 8'hC2);
    drain("after_rst", 300);

    // neighbouring registers are ignored
    reg_write(16'hFF45, 8'h33);
    reg_write(16'hFF47, 8'h44);
    repeat (5) @(posedge clk_sys);
    #2;
    chk("ign_cpu_do", cpu_do, 8'hC2);
    chk("ign_act", dma_active, 1'b0);
    chk("ign_rd", dma_rd, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
